// File: rtl/gift_inv_core.sv
// Iterative GIFT-64/GIFT-128 decryption core: one inverse round per clock, with the
// final-round key schedule state cached so repeated keys can skip the forward expansion.
module gift_inv_core #(
    parameter int BLOCK_BITS = 128
) (
    input  logic                  inClk,
    input  logic                  inRstN,
    input  logic                  inValid,
    output logic                  outReady,
    input  logic [BLOCK_BITS-1:0] inData,
    input  logic [127:0]          inKey,
    input  logic                  inKeyReuse,
    output logic                  outValid,
    output logic [BLOCK_BITS-1:0] outData,
    input  logic                  inAck
);

    localparam int ROUNDS      = (BLOCK_BITS == 128) ? 40 : 28;
    localparam int CNT_W       = $clog2(ROUNDS);
    localparam int PERM_STRIDE = BLOCK_BITS / 4;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] EXPAND = 2'd1;
    localparam logic [1:0] ROUND  = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    generate
        if (BLOCK_BITS != 128 && BLOCK_BITS != 64) begin : g_bad_width
            $error("gift_inv_core: BLOCK_BITS must be 128 or 64");
        end
    endgenerate

    logic [1:0]            state;
    logic [BLOCK_BITS-1:0] blk;
    logic [127:0]          key;
    logic [127:0]          cache_key;
    logic [5:0]            lfsr;
    logic [5:0]            cache_lfsr;
    logic                  cache_valid;
    logic [CNT_W-1:0]      cnt;

    logic [127:0]          key_next;
    logic [127:0]          key_prev;
    logic [5:0]            lfsr_next;
    logic [5:0]            lfsr_prev;
    logic [BLOCK_BITS-1:0] ark;
    logic [BLOCK_BITS-1:0] perm;
    logic [BLOCK_BITS-1:0] round_out;

    function automatic logic [3:0] inv_sbox(input logic [3:0] x);
        case (x)
            4'h0:    return 4'hd;
            4'h1:    return 4'h0;
            4'h2:    return 4'h8;
            4'h3:    return 4'h6;
            4'h4:    return 4'h2;
            4'h5:    return 4'hc;
            4'h6:    return 4'h4;
            4'h7:    return 4'hb;
            4'h8:    return 4'he;
            4'h9:    return 4'h7;
            4'ha:    return 4'h1;
            4'hb:    return 4'ha;
            4'hc:    return 4'h3;
            4'hd:    return 4'h9;
            4'he:    return 4'hf;
            default: return 4'h5;
        endcase
    endfunction

    // Forward step rotates k1/k0 into the top words; the inverse rotates them back out.
    assign key_next  = {key[17:16], key[31:18], key[11:0], key[15:12], key[127:32]};
    assign key_prev  = {key[95:0], key[125:112], key[127:126], key[99:96], key[111:100]};
    assign lfsr_next = {lfsr[4:0], lfsr[5] ^ lfsr[4] ^ 1'b1};
    assign lfsr_prev = {lfsr[0] ^ lfsr[5] ^ 1'b1, lfsr[5:1]};

    always_comb begin
        ark = blk;
        for (int i = 0; i < BLOCK_BITS / 4; i++) begin
            if (BLOCK_BITS == 128) begin
                ark[4*i+2] = ark[4*i+2] ^ key[64+i];
                ark[4*i+1] = ark[4*i+1] ^ key[i];
            end else begin
                ark[4*i+1] = ark[4*i+1] ^ key[16+i];
                ark[4*i]   = ark[4*i]   ^ key[i];
            end
        end
        ark[23]           = ark[23] ^ lfsr[5];
        ark[19]           = ark[19] ^ lfsr[4];
        ark[15]           = ark[15] ^ lfsr[3];
        ark[11]           = ark[11] ^ lfsr[2];
        ark[7]            = ark[7]  ^ lfsr[1];
        ark[3]            = ark[3]  ^ lfsr[0];
        ark[BLOCK_BITS-1] = ark[BLOCK_BITS-1] ^ 1'b1;
    end

    // The forward permutation sends bit i to P(i), so the inverse gathers from P(i).
    always_comb begin
        perm = '0;
        for (int i = 0; i < BLOCK_BITS; i++) begin
            perm[i] = ark[4*(i/16) + PERM_STRIDE*((3*((i%16)/4) + (i%4)) % 4) + (i%4)];
        end
    end

    always_comb begin
        round_out = '0;
        for (int i = 0; i < BLOCK_BITS / 4; i++) begin
            round_out[4*i +: 4] = inv_sbox(perm[4*i +: 4]);
        end
    end

    assign outReady = (state == IDLE);

    always_ff @(posedge inClk or negedge inRstN) begin
        if (!inRstN) begin
            state       <= IDLE;
            blk         <= '0;
            key         <= '0;
            cache_key   <= '0;
            lfsr        <= '0;
            cache_lfsr  <= '0;
            cache_valid <= 1'b0;
            cnt         <= '0;
            outValid    <= 1'b0;
            outData     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (inValid) begin
                        blk <= inData;
                        if (inKeyReuse && cache_valid) begin
                            key   <= cache_key;
                            lfsr  <= cache_lfsr;
                            cnt   <= CNT_W'(ROUNDS - 1);
                            state <= ROUND;
                        end else begin
                            key   <= inKey;
                            lfsr  <= 6'b000001;
                            cnt   <= CNT_W'(ROUNDS - 2);
                            state <= EXPAND;
                        end
                    end
                end
                EXPAND: begin
                    key  <= key_next;
                    lfsr <= lfsr_next;
                    if (cnt == '0) begin
                        cache_key   <= key_next;
                        cache_lfsr  <= lfsr_next;
                        cache_valid <= 1'b1;
                        cnt         <= CNT_W'(ROUNDS - 1);
                        state       <= ROUND;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ROUND: begin
                    blk  <= round_out;
                    key  <= key_prev;
                    lfsr <= lfsr_prev;
                    if (cnt == '0) begin
                        outData  <= round_out;
                        outValid <= 1'b1;
                        state    <= DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    if (inAck) begin
                        outValid <= 1'b0;
                        state    <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gift_inv_core.sv
// Bench for gift_inv_core: a 128-bit and a 64-bit instance are driven with ciphertexts
// produced by a forward GIFT encryption model, and must return the original plaintexts.
module tb_gift_inv_core;

    localparam logic [63:0] GS_TABLE = 64'hE8057BD293F6C4A1;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;

    logic         valid_128 = 1'b0;
    logic         reuse_128 = 1'b0;
    logic         ack_128 = 1'b0;
    logic [127:0] data_128 = '0;
    logic [127:0] key_128 = '0;
    logic         ready_128;
    logic         ovalid_128;
    logic [127:0] odata_128;

    logic         valid_64 = 1'b0;
    logic         reuse_64 = 1'b0;
    logic         ack_64 = 1'b0;
    logic [63:0]  data_64 = '0;
    logic [127:0] key_64 = '0;
    logic         ready_64;
    logic         ovalid_64;
    logic [63:0]  odata_64;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    gift_inv_core #(.BLOCK_BITS(128)) dut_128 (
        .inClk(clk), .inRstN(rst_n), .inValid(valid_128), .outReady(ready_128),
        .inData(data_128), .inKey(key_128), .inKeyReuse(reuse_128),
        .outValid(ovalid_128), .outData(odata_128), .inAck(ack_128)
    );

    gift_inv_core #(.BLOCK_BITS(64)) dut_64 (
        .inClk(clk), .inRstN(rst_n), .inValid(valid_64), .outReady(ready_64),
        .inData(data_64), .inKey(key_64), .inKeyReuse(reuse_64),
        .outValid(ovalid_64), .outData(odata_64), .inAck(ack_64)
    );

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Forward GIFT encryption: SubCells, PermBits, AddRoundKey, then key schedule.
    function automatic logic [127:0] model_enc(input logic [127:0] pt, input logic [127:0] k, input int n);
        logic [127:0] s;
        logic [127:0] t;
        logic [15:0]  w [8];
        logic [15:0]  nw [8];
        logic [5:0]   c;
        logic [3:0]   nib;
        int           rounds;
        int           p;
        rounds = (n == 128) ? 40 : 28;
        s = pt;
        c = 6'd0;
        for (int j = 0; j < 8; j++) w[j] = k[16*j +: 16];
        for (int r = 0; r < rounds; r++) begin
            for (int i = 0; i < n / 4; i++) begin
                nib = s[4*i +: 4];
                s[4*i +: 4] = GS_TABLE[4*nib +: 4];
            end
            t = '0;
            for (int i = 0; i < n; i++) begin
                p = 4*(i/16) + (n/4)*((3*((i%16)/4) + (i%4)) % 4) + (i%4);
                t[p] = s[i];
            end
            s = t;
            if (n == 128) begin
                for (int i = 0; i < 32; i++) begin
                    s[4*i+2] = s[4*i+2] ^ w[4 + i/16][i%16];
                    s[4*i+1] = s[4*i+1] ^ w[i/16][i%16];
                end
            end else begin
                for (int i = 0; i < 16; i++) begin
                    s[4*i+1] = s[4*i+1] ^ w[1][i];
                    s[4*i]   = s[4*i]   ^ w[0][i];
                end
            end
            c = {c[4:0], c[5] ^ c[4] ^ 1'b1};
            s[23] = s[23] ^ c[5];
            s[19] = s[19] ^ c[4];
            s[15] = s[15] ^ c[3];
            s[11] = s[11] ^ c[2];
            s[7]  = s[7]  ^ c[1];
            s[3]  = s[3]  ^ c[0];
            s[n-1] = s[n-1] ^ 1'b1;
            nw[7] = {w[1][1:0], w[1][15:2]};
            nw[6] = {w[0][11:0], w[0][15:12]};
            for (int j = 0; j < 6; j++) nw[j] = w[j+2];
            w = nw;
        end
        return s;
    endfunction

    task automatic do_req(input bit wide, input logic [127:0] ct, input logic [127:0] k,
                          input bit reuse, output int lat, output logic [127:0] pt);
        if (wide) begin
            valid_128 = 1'b1; data_128 = ct; key_128 = k; reuse_128 = reuse;
        end else begin
            valid_64 = 1'b1; data_64 = ct[63:0]; key_64 = k; reuse_64 = reuse;
        end
        @(posedge clk); #1;
        if (wide) valid_128 = 1'b0;
        else      valid_64 = 1'b0;
        lat = 0;
        while (!(wide ? ovalid_128 : ovalid_64) && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        pt = wide ? odata_128 : {64'd0, odata_64};
    endtask

    task automatic do_ack(input bit wide);
        if (wide) ack_128 = 1'b1;
        else      ack_64 = 1'b1;
        @(posedge clk); #1;
        ack_128 = 1'b0;
        ack_64  = 1'b0;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({ready_128, ovalid_128, odata_128} !== {1'b1, 1'b0, 128'd0}) begin
            errors++;
            $display("[TB] FAIL reset128 async: got ready=%b valid=%b data=%h expected 1 0 0", ready_128, ovalid_128, odata_128);
        end
        checks++;
        if ({ready_64, ovalid_64, odata_64} !== {1'b1, 1'b0, 64'd0}) begin
            errors++;
            $display("[TB] FAIL reset64 async: got ready=%b valid=%b data=%h expected 1 0 0", ready_64, ovalid_64, odata_64);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({ready_128, ovalid_128, ready_64, ovalid_64} !== 4'b1010) begin
            errors++;
            $display("[TB] FAIL reset clocked: got %b expected 1010", {ready_128, ovalid_128, ready_64, ovalid_64});
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({ready_128, ready_64} !== 2'b11) begin
            errors++;
            $display("[TB] FAIL idle after reset: got %b expected 11", {ready_128, ready_64});
        end
    endtask

    task automatic test_known_vectors();
        logic [127:0] ct, got, k;
        int lat;
        ct = model_enc(128'd0, 128'd0, 128);
        do_req(1'b1, ct, 128'd0, 1'b0, lat, got);
        checks++;
        if (lat !== 79) begin errors++; $display("[TB] FAIL zero128 latency: got %0d expected 79", lat); end
        checks++;
        if (got !== 128'd0) begin errors++; $display("[TB] FAIL zero128 data: got %h expected 0", got); end
        do_ack(1'b1);

        k  = 128'h000102030405060708090A0B0C0D0E0F;
        ct = model_enc({64'd0, 64'hFEDCBA9876543210}, k, 64);
        do_req(1'b0, ct, k, 1'b0, lat, got);
        checks++;
        if (lat !== 55) begin errors++; $display("[TB] FAIL vec64 latency: got %0d expected 55", lat); end
        checks++;
        if (got[63:0] !== 64'hFEDCBA9876543210) begin
            errors++; $display("[TB] FAIL vec64 data: got %h expected fedcba9876543210", got[63:0]);
        end
        do_ack(1'b0);
    endtask

    task automatic test_key_reuse();
        logic [127:0] k, pt, ct, got;
        int lat;
        pulse_reset();
        for (int w = 0; w < 2; w++) begin
            k = rand128();
            for (int pass = 0; pass < 2; pass++) begin
                pt = rand128();
                if (w == 1) pt[127:64] = '0;
                ct = model_enc(pt, k, (w == 0) ? 128 : 64);
                do_req(w == 0, ct, k, 1'b1, lat, got);
                checks++;
                if (lat !== ((pass == 0) ? ((w == 0) ? 79 : 55) : ((w == 0) ? 40 : 28))) begin
                    errors++;
                    $display("[TB] FAIL reuse latency w%0d pass%0d: got %0d", w, pass, lat);
                end
                checks++;
                if (got !== pt) begin
                    errors++;
                    $display("[TB] FAIL reuse data w%0d pass%0d: got %h expected %h", w, pass, got, pt);
                end
                do_ack(w == 0);
            end
        end
    endtask

    task automatic test_done_hold();
        logic [127:0] k, pt, ct;
        int lat;
        k = rand128(); pt = rand128(); ct = model_enc(pt, k, 128);
        valid_128 = 1'b1; data_128 = ct; key_128 = k; reuse_128 = 1'b0;
        @(posedge clk); #1;
        valid_128 = 1'b0;
        lat = 0;
        while (!ovalid_128 && lat < 200) begin
            valid_128 = (lat == 10 || lat == 50);
            ack_128   = (lat == 60);
            if (valid_128) data_128 = rand128();
            @(posedge clk); #1;
            lat++;
            if (lat == 11 || lat == 51) begin
                checks++;
                if (ready_128 !== 1'b0) begin
                    errors++; $display("[TB] FAIL busy ready at %0d: got %b expected 0", lat, ready_128);
                end
            end
        end
        valid_128 = 1'b0;
        ack_128   = 1'b0;
        checks++;
        if (lat !== 79) begin errors++; $display("[TB] FAIL ignore latency: got %0d expected 79", lat); end
        checks++;
        if (odata_128 !== pt) begin errors++; $display("[TB] FAIL ignore data: got %h expected %h", odata_128, pt); end
        for (int c = 0; c < 10; c++) begin
            valid_128 = (c % 2 == 1);
            @(posedge clk); #1;
            checks++;
            if ({ready_128, ovalid_128, odata_128} !== {1'b0, 1'b1, pt}) begin
                errors++;
                $display("[TB] FAIL done hold %0d: got ready=%b valid=%b data=%h expected 0 1 %h", c, ready_128, ovalid_128, odata_128, pt);
            end
        end
        valid_128 = 1'b1; ack_128 = 1'b1; data_128 = rand128();
        @(posedge clk); #1;
        valid_128 = 1'b0; ack_128 = 1'b0;
        checks++;
        if ({ready_128, ovalid_128} !== 2'b10) begin
            errors++; $display("[TB] FAIL ack release: got ready=%b valid=%b expected 1 0", ready_128, ovalid_128);
        end
        @(posedge clk); #1;
        checks++;
        if (ready_128 !== 1'b1) begin
            errors++; $display("[TB] FAIL ack with valid accepted: got ready=%b expected 1", ready_128);
        end
    endtask

    task automatic test_reset_abort();
        logic [127:0] k, pt, ct, got;
        int lat;
        k = rand128(); pt = rand128(); ct = model_enc(pt, k, 128);
        valid_128 = 1'b1; data_128 = ct; key_128 = k; reuse_128 = 1'b0;
        @(posedge clk); #1;
        valid_128 = 1'b0;
        repeat (59) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({ready_128, ovalid_128, odata_128} !== {1'b1, 1'b0, 128'd0}) begin
            errors++;
            $display("[TB] FAIL abort outputs: got ready=%b valid=%b data=%h expected 1 0 0", ready_128, ovalid_128, odata_128);
        end
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            checks++;
            if (ovalid_128 !== 1'b0) begin errors++; $display("[TB] FAIL abort valid %0d: got %b expected 0", c, ovalid_128); end
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        pt = rand128(); ct = model_enc(pt, k, 128);
        do_req(1'b1, ct, k, 1'b1, lat, got);
        checks++;
        if (lat !== 79) begin errors++; $display("[TB] FAIL post-abort latency: got %0d expected 79", lat); end
        checks++;
        if (got !== pt) begin errors++; $display("[TB] FAIL post-abort data: got %h expected %h", got, pt); end
        do_ack(1'b1);
    endtask

    task automatic test_random(input bit wide, input int count);
        logic [127:0] k, pt, ct, got;
        bit have_cache;
        bit reuse;
        int lat, n, exp_lat;
        n = wide ? 128 : 64;
        have_cache = 1'b0;
        k = '0;
        for (int t = 0; t < count; t++) begin
            reuse = have_cache && ($urandom_range(3) != 0);
            if (!reuse) k = rand128();
            pt = rand128();
            if (!wide) pt[127:64] = '0;
            ct = model_enc(pt, k, n);
            exp_lat = reuse ? (wide ? 40 : 28) : (wide ? 79 : 55);
            do_req(wide, ct, k, reuse, lat, got);
            checks++;
            if (lat !== exp_lat) begin
                errors++; $display("[TB] FAIL random%0d latency #%0d: got %0d expected %0d", n, t, lat, exp_lat);
            end
            checks++;
            if (got !== pt) begin
                errors++; $display("[TB] FAIL random%0d data #%0d: got %h expected %h", n, t, got, pt);
            end
            do_ack(wide);
            have_cache = 1'b1;
        end
    endtask

    initial begin
        test_reset();
        test_known_vectors();
        test_key_reuse();
        test_done_hold();
        test_reset_abort();
        fork
            test_random(1'b1, 1000);
            test_random(1'b0, 1000);
        join
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gift_inv_core.md
GIFT_INV_CORE -- requirements
Module: gift_inv_core

Interface
REQ-001 The module SHALL have parameter BLOCK_BITS, default 128, cipher block width: 128 selects GIFT-128, 64 selects GIFT-64; any other value SHALL be a compile-time error.
REQ-002 The module SHALL derive localparam ROUNDS = 40 for BLOCK_BITS=128 and 28 for BLOCK_BITS=64.
REQ-003 The module SHALL have these ports:
  inClk  input  1  sole clock, all state on rising edge.
  inRstN  input  1  reset, asynchronous, active-low.
  inValid  input  1  request strobe: inData/inKey/inKeyReuse valid.
  outReady  output  1  core idle and able to accept a request.
  inData  input  BLOCK_BITS  ciphertext.
  inKey  input  128  master key, words k7..k0 (k0 = bits 15:0).
  inKeyReuse  input  1  use the cached final-round key state and skip expansion.
  outValid  output  1  plaintext on outData.
  outData  output  BLOCK_BITS  plaintext, registered.
  inAck  input  1  downstream consumed outData.

Function
REQ-004 The core SHALL implement states IDLE, EXPAND, ROUND and DONE; outReady=1 only in IDLE.
REQ-005 In IDLE, inValid=1 SHALL register inData into the state register, load the LFSR constant with 6'b000001 and load the round counter; inValid in any other state SHALL be ignored.
REQ-006 On accept with inKeyReuse=0, or with no valid cache, the core SHALL load inKey and go to EXPAND; with inKeyReuse=1 and a valid cache, it SHALL load the cached key state and constant 6'b(constant of round ROUNDS-1) and go to ROUND.
REQ-007 EXPAND SHALL last exactly ROUNDS-1 cycles; each cycle SHALL apply the forward key update k7..k0 <= (k1>>>2)||(k0>>>12)||k7..k2 and the forward LFSR step c <= {c4..c0, c5^c4^1}.
REQ-008 On leaving EXPAND, the key state and constant SHALL be written to the cache and the cache SHALL be marked valid.
REQ-009 ROUND SHALL last exactly ROUNDS cycles, one inverse round per cycle, in this order: AddRoundKey with the current key/constant, then inverse bit permutation, then inverse S-box; after the round, the key and LFSR SHALL step in inverse.
REQ-010 AddRoundKey for BLOCK_BITS=128 SHALL XOR U=k5||k4 into bits 4i+2 and V=k1||k0 into bits 4i+1 (i=0..31).
REQ-011 AddRoundKey for BLOCK_BITS=64 SHALL XOR U=k1 into bits 4i+1 and V=k0 into bits 4i (i=0..15).
REQ-012 For both widths, AddRoundKey SHALL XOR c5..c0 into bits 23,19,15,11,7,3 and XOR 1 into bit BLOCK_BITS-1.
REQ-013 After the last ROUND cycle, outData SHALL be updated, outValid SHALL be set, and the state SHALL be DONE; total latency from the accept edge SHALL be 2*ROUNDS-1 cycles (full) or ROUNDS cycles (reuse).
REQ-014 In DONE, outValid and outData SHALL hold until inAck=1; on that edge outValid SHALL clear and the state SHALL go to IDLE, giving outReady=1 on the next cycle.
REQ-015 inAck outside DONE SHALL be ignored; inValid and inAck in the same DONE cycle SHALL NOT accept the new request.
REQ-016 The round counter SHALL be wide enough for ROUNDS-1 and SHALL never wrap within a state.

Reset
REQ-017 While inRstN=0, regardless of clock, the state SHALL be IDLE, outReady=1, outValid=0, outData=0, and the state, key, cache and LFSR registers SHALL be 0 with the cache marked invalid.
REQ-018 Reset asserted mid-EXPAND or mid-ROUND SHALL abort the operation with no outValid pulse and SHALL invalidate the cache.

Verification
REQ-019 BLOCK_BITS=128, key=0, ciphertext = model Enc(0,0) -> outData=128'h0 and outValid rises exactly 79 cycles after accept.
REQ-020 BLOCK_BITS=64, key=128'h000102...0F, ciphertext = model Enc(64'hFEDCBA9876543210) -> that plaintext after 55 cycles.
REQ-021 Second request with inKeyReuse=1 and the same key -> correct plaintext after 40 cycles (128); a reuse request directly after reset -> full 79-cycle path.
REQ-022 inAck held 0 for 10 cycles in DONE -> outValid/outData stable; inValid pulses during EXPAND/ROUND/DONE -> ignored, outReady=0.
REQ-023 inRstN pulled low at ROUND cycle 20 -> outputs cleared immediately, no outValid; next request decrypts correctly with full expansion.
REQ-024 Random 1000 key/ciphertext pairs per width against the bit-exact model -> zero mismatches.
